vga_timing_monitor: RTL and testbench



---
 rtl/vga_timing_monitor.sv | 226 ++++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers line/frame geometry from HS/VS, signs active pixels, reports lock.
// Optional macro VGA_MON_CRC_EN selects a CRC-32 frame signature instead of the additive sum.
module vga_timing_monitor #(
  parameter int CLK_PER_PIX = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  output logic [11:0] h_period,
  output logic [11:0] h_pulse,
  output logic [9:0]  v_lines,
  output logic [9:0]  v_pulse,
  output logic [31:0] frame_sig,
  output logic [18:0] pix_count,
  output logic        locked,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);

  localparam int PH_W    = $clog2(CLK_PER_PIX);
  localparam int TIMEOUT = 2 * H_TOTAL * CLK_PER_PIX;
  localparam int TW      = $clog2(TIMEOUT + 1);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_PER_PIX - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLK_PER_PIX / 2);
  localparam logic [10:0] COL_LO  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] COL_HI  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  LINE_LO = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  LINE_HI = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [11:0] EXP_HPER  = 12'(H_TOTAL * CLK_PER_PIX);
  localparam logic [11:0] EXP_HPUL  = 12'(H_SYNC * CLK_PER_PIX);
  localparam logic [9:0]  EXP_LINES = 10'(V_TOTAL);
  localparam logic [9:0]  EXP_VPUL  = 10'(V_SYNC);

`ifdef VGA_MON_CRC_EN
  localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [11:0] w);
    logic [31:0] c;
    c = s;
    for (int i = 11; i >= 0; i--) begin
      if (c[31] ^ w[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction
`else
  localparam logic [31:0] SIG_INIT = 32'h0000_0000;

  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [11:0] w);
    return s + {20'd0, w};
  endfunction
`endif

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  state_t state, state_nxt;

  logic            hs_q, hs_qq, vs_q, vs_qq;
  logic [11:0]     rgb_q;
  logic            hs_fall, vs_fall;
  logic [PH_W-1:0] ph;
  logic [10:0]     col;
  logic [11:0]     hcnt, hlow, last_period, last_pulse;
  logic [9:0]      vcnt, vlow;
  logic [31:0]     sig_acc;
  logic [18:0]     pix_acc;
  logic [TW-1:0]   tmr;
  logic [11:0]     period_nxt, pulse_nxt;
  logic [9:0]      lines_nxt;
  logic            samp, timeout, geom_ok, latch, err_inc;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      rgb_q <= '0;
    end else begin
      hs_q  <= VGA_HS;
      hs_qq <= hs_q;
      vs_q  <= VGA_VS;
      vs_qq <= vs_q;
      rgb_q <= {VGA_R, VGA_G, VGA_B};
    end
  end

  assign hs_fall = hs_qq & ~hs_q;
  assign vs_fall = vs_qq & ~vs_q;

  // The HS-fall cycle is position 0; ph/col/hcnt describe the cycles after it.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      ph          <= '0;
      col         <= '0;
      hcnt        <= '0;
      hlow        <= '0;
      last_period <= '0;
      last_pulse  <= '0;
    end else if (hs_fall) begin
      ph          <= PH_W'(1);
      col         <= '0;
      hcnt        <= 12'd1;
      hlow        <= 12'd1;
      last_period <= hcnt;
      last_pulse  <= hlow;
    end else begin
      if (hcnt != '1) hcnt <= hcnt + 12'd1;
      if (!hs_q && hlow != '1) hlow <= hlow + 12'd1;
      if (ph == PH_LAST) begin
        ph <= '0;
        if (col != '1) col <= col + 11'd1;
      end else begin
        ph <= ph + PH_W'(1);
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      vcnt    <= '0;
      vlow    <= '0;
      sig_acc <= SIG_INIT;
      pix_acc <= '0;
    end else if (vs_fall) begin
      vcnt    <= '0;
      vlow    <= {9'd0, hs_fall};
      sig_acc <= SIG_INIT;
      pix_acc <= '0;
    end else begin
      if (hs_fall && vcnt != '1) vcnt <= vcnt + 10'd1;
      if (hs_fall && !vs_q && vlow != '1) vlow <= vlow + 10'd1;
      if (samp) begin
        sig_acc <= sig_step(sig_acc, rgb_q);
        if (pix_acc != '1) pix_acc <= pix_acc + 19'd1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n)       tmr <= '0;
    else if (hs_fall) tmr <= TW'(TIMEOUT - 1);
    else if (tmr != '0) tmr <= tmr - TW'(1);
  end

  // A line ending on the VS-fall clock still belongs to the frame being closed.
  assign period_nxt = hs_fall ? hcnt : last_period;
  assign pulse_nxt  = hs_fall ? hlow : last_pulse;
  assign lines_nxt  = (hs_fall && vcnt != '1) ? vcnt + 10'd1 : vcnt;

  assign samp = !hs_fall && !vs_fall && (ph == PH_MID) &&
                (col >= COL_LO) && (col < COL_HI) &&
                (vcnt >= LINE_LO) && (vcnt < LINE_HI);

  assign timeout = (state != S_SEARCH) && !hs_fall && (tmr == '0);
  assign geom_ok = (period_nxt == EXP_HPER) && (pulse_nxt == EXP_HPUL) &&
                   (lines_nxt == EXP_LINES) && (vlow == EXP_VPUL);

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    err_inc   = 1'b0;
    case (state)
      S_SEARCH: begin
        if (vs_fall) state_nxt = S_MEASURE;
      end
      S_MEASURE, S_LOCKED: begin
        if (timeout) begin
          state_nxt = S_SEARCH;
          err_inc   = 1'b1;
        end else if (vs_fall) begin
          latch = 1'b1;
          if (geom_ok) begin
            state_nxt = S_LOCKED;
          end else begin
            state_nxt = S_MEASURE;
            err_inc   = 1'b1;
          end
        end
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SEARCH;
      frame_done <= 1'b0;
      err_cnt    <= '0;
      h_period   <= '0;
      h_pulse    <= '0;
      v_lines    <= '0;
      v_pulse    <= '0;
      frame_sig  <= '0;
      pix_count  <= '0;
    end else begin
      state      <= state_nxt;
      frame_done <= latch;
      if (err_inc && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
      if (latch) begin
        h_period  <= period_nxt;
        h_pulse   <= pulse_nxt;
        v_lines   <= lines_nxt;
        v_pulse   <= vlow;
        frame_sig <= sig_acc;
        pix_count <= pix_acc;
      end
    end
  end

  assign locked = (state == S_LOCKED);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a shrunken raster: random frames, geometry faults, HS silence, mid-frame reset.
// Signature reference follows VGA_MON_CRC_EN the same way the design does.
module tb_vga_timing_monitor;
  localparam int CPP  = 4;
  localparam int HT   = 24;
  localparam int HS_W = 3;
  localparam int HBP  = 2;
  localparam int HA   = 16;
  localparam int VT   = 14;
  localparam int VS_W = 2;
  localparam int VBP  = 2;
  localparam int VA   = 8;
  localparam int COL0 = HS_W + HBP;
  localparam int ROW0 = VS_W + VBP;
  localparam int TOUT = 2 * HT * CPP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        hs = 1'b1, vs = 1'b1;
  logic [11:0] h_period, h_pulse;
  logic [9:0]  v_lines, v_pulse;
  logic [31:0] frame_sig;
  logic [18:0] pix_count;
  logic        locked, frame_done;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .CLK_PER_PIX(CPP), .H_TOTAL(HT), .H_SYNC(HS_W), .H_BP(HBP), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS_W), .V_BP(VBP), .V_ACTIVE(VA)
  ) dut (
    .CLK100MHZ(clk), .rst_n(rst_n),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .VGA_HS(hs), .VGA_VS(vs),
    .h_period(h_period), .h_pulse(h_pulse), .v_lines(v_lines), .v_pulse(v_pulse),
    .frame_sig(frame_sig), .pix_count(pix_count), .locked(locked),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  int          n_cmp = 0, n_bad = 0;
  logic [11:0] pixmem [VA][HA];
  bit          exp_search = 1'b1, exp_lock = 1'b0;
  int          exp_err = 0;
  int          prev_ht = 0, prev_vt = 0, prev_pix = 0;
  logic [31:0] prev_sig = '0;
  int          fd_seen = 0, since_hs = 0;
  logic        hs_prev = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference signature over the pixels the frame actually carries, scanned line by line.
  function automatic logic [31:0] model_sig(input int ht, input int vt);
    logic [31:0] s;
`ifdef VGA_MON_CRC_EN
    s = 32'hFFFF_FFFF;
`else
    s = 32'h0;
`endif
    for (int l = 0; l < VA; l++)
      for (int p = 0; p < HA; p++)
        if (ROW0 + l < vt && COL0 + p < ht) begin
`ifdef VGA_MON_CRC_EN
          s = s ^ {pixmem[l][p], 20'd0};
          repeat (12) s = s[31] ? ({s[30:0], 1'b0} ^ 32'h04C1_1DB7) : {s[30:0], 1'b0};
`else
          s = s + {20'd0, pixmem[l][p]};
`endif
        end
    return s;
  endfunction

  function automatic int model_pix(input int ht, input int vt);
    int n = 0;
    for (int l = 0; l < VA; l++)
      for (int p = 0; p < HA; p++)
        if (ROW0 + l < vt && COL0 + p < ht) n++;
    return n;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_h_period"},   32'(h_period),   32'd0);
    chk({tag, "_h_pulse"},    32'(h_pulse),    32'd0);
    chk({tag, "_v_lines"},    32'(v_lines),    32'd0);
    chk({tag, "_v_pulse"},    32'(v_pulse),    32'd0);
    chk({tag, "_frame_sig"},  frame_sig,       32'd0);
    chk({tag, "_pix_count"},  32'(pix_count),  32'd0);
    chk({tag, "_locked"},     32'(locked),     32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
  endtask

  // One input clock: sample the previous edge's results, then drive this cycle's pins.
  task automatic cyc(input logic hsv, input logic vsv, input logic [11:0] w, input int pos);
    @(negedge clk);
    if (frame_done === 1'b1) begin
      fd_seen++;
      chk("fd_pos",    32'(pos),       32'd2);
      chk("h_period",  32'(h_period),  32'(prev_ht * CPP));
      chk("h_pulse",   32'(h_pulse),   32'(HS_W * CPP));
      chk("v_lines",   32'(v_lines),   32'((prev_vt > 1023) ? 1023 : prev_vt));
      chk("v_pulse",   32'(v_pulse),   32'(VS_W));
      chk("frame_sig", frame_sig,      prev_sig);
      chk("pix_count", 32'(pix_count), 32'(prev_pix));
      chk("locked",    32'(locked),    32'(exp_lock));
      chk("err_cnt",   32'(err_cnt),   32'(exp_err));
    end
    hs = hsv;
    vs = vsv;
    {r, g, b} = w;
    if (hs_prev && !hsv) since_hs = 0;
    else since_hs++;
    hs_prev = hsv;
  endtask

  // mode: 0 new random picture, 1 repeat last picture, 2 black picture.
  task automatic run_frame(input int ht, input int vt, input int mode, input int rst_line);
    bit          exp_fd;
    logic [31:0] sig;
    int          pc, rst_hold;
    logic [11:0] w;
    if (mode == 0) begin
      for (int l = 0; l < VA; l++) for (int p = 0; p < HA; p++) pixmem[l][p] = 12'($urandom);
    end else if (mode == 2) begin
      for (int l = 0; l < VA; l++) for (int p = 0; p < HA; p++) pixmem[l][p] = 12'd0;
    end
    sig = model_sig(ht, vt);
    pc  = model_pix(ht, vt);
    exp_fd = !exp_search;
    if (exp_search) exp_search = 1'b0;
    else if (prev_ht == HT && prev_vt == VT) exp_lock = 1'b1;
    else begin
      exp_lock = 1'b0;
      if (exp_err < 255) exp_err++;
    end
    fd_seen  = 0;
    rst_hold = 0;
    for (int l = 0; l < vt; l++)
      for (int p = 0; p < ht; p++)
        for (int k = 0; k < CPP; k++) begin
          if (l == rst_line && p == 0 && k == 0) begin
            rst_n = 1'b0;
            #1;
            check_zero("midrst");
            exp_search = 1'b1;
            exp_lock   = 1'b0;
            exp_err    = 0;
            rst_hold   = 10;
          end
          if (l >= ROW0 && l < ROW0 + VA && p >= COL0 && p < COL0 + HA) w = pixmem[l-ROW0][p-COL0];
          else w = 12'd0;
          cyc(!(p < HS_W), !(l < VS_W), w, (l * ht + p) * CPP + k);
          if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) rst_n = 1'b1;
          end
        end
    chk("fd_count", 32'(fd_seen), 32'(exp_fd));
    prev_ht  = ht;
    prev_vt  = vt;
    prev_sig = sig;
    prev_pix = pc;
  endtask

  // Sync lines held inactive; lock must drop roughly TOUT clocks after the last HS fall.
  task automatic drive_idle(input int n);
    fd_seen = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, 12'd0, 1000000 + i);
      if (since_hs == TOUT - 2) chk("pre_timeout_locked", 32'(locked), 32'(exp_lock));
      if (since_hs == TOUT + 4) begin
        exp_lock   = 1'b0;
        exp_search = 1'b1;
        if (exp_err < 255) exp_err++;
        chk("timeout_locked",  32'(locked),   32'(exp_lock));
        chk("timeout_err_cnt", 32'(err_cnt),  32'(exp_err));
        chk("timeout_hold",    32'(h_period), 32'(HT * CPP));
      end
    end
    chk("idle_fd_count", 32'(fd_seen), 32'd0);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    run_frame(HT, VT, 0, -1);       // first VS fall only arms measurement
    run_frame(HT, VT, 0, -1);       // first report, lock
    run_frame(HT, VT, 0, -1);       // new picture
    run_frame(HT, VT, 1, -1);       // repeated picture

    run_frame(HT + 1, VT, 0, -1);   // wrong line length
    run_frame(HT + 1, VT, 0, -1);
    run_frame(HT + 1, VT, 0, -1);
    run_frame(HT, VT, 0, -1);
    run_frame(HT, VT, 0, -1);       // re-lock

    run_frame(HT, VT, 2, -1);       // black picture
    run_frame(HT, VT, 0, -1);

    run_frame(4, 1030, 0, -1);      // line count saturates at 1023
    run_frame(HT, VT, 0, -1);
    run_frame(HT, VT, 0, -1);

    drive_idle(160);                // HS silence while locked
    run_frame(HT, VT, 0, -1);
    run_frame(HT, VT, 0, -1);

    run_frame(HT, VT, 0, 5);        // reset at line 5
    run_frame(HT, VT, 0, -1);
    run_frame(HT, VT, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
